// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default sizes and the
// ownership state encoding.
package mem_arb_pkg;

    localparam int S  = 32;
    localparam int L  = 256;
    localparam int AW = $clog2(L);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_rport.sv
// Per-port read return register: captures the memory word on a granted read
// and presents it with a one-cycle valid pulse.
module mem_arb_rport
    import mem_arb_pkg::*;
#(
    parameter int DW = mem_arb_pkg::S
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    // rdata is only overwritten by a new read, so it holds between reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= din;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter with round-robin tie breaking and a lock
// mechanism that lets one port keep exclusive ownership across accesses.
module mem_arbiter #(
    parameter int S  = mem_arb_pkg::S,
    parameter int L  = mem_arb_pkg::L,
    parameter int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [S-1:0]  wdata0,
    output logic          gnt0,
    output logic [S-1:0]  rdata0,
    output logic          rvalid0,

    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [S-1:0]  wdata1,
    output logic          gnt1,
    output logic [S-1:0]  rdata1,
    output logic          rvalid1,

    output logic [AW-1:0] mem_a,
    output logic [S-1:0]  mem_din,
    input  logic [S-1:0]  mem_dout,
    output logic          mem_mread,
    output logic          mem_mwrite
);

    import mem_arb_pkg::*;

    state_t state;
    state_t nextState;
    logic   lastGnt;

    // Grants are suppressed entirely while in reset so nothing reaches memory
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        nextState = state;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0 = lastGnt;
                        gnt1 = ~lastGnt;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
            if (gnt0) begin
                nextState = lock0 ? OWN0 : IDLE;
            end else if (gnt1) begin
                nextState = lock1 ? OWN1 : IDLE;
            end
        end
    end

    always_comb begin
        mem_a      = '0;
        mem_din    = '0;
        mem_mwrite = 1'b0;
        mem_mread  = 1'b0;
        if (gnt0) begin
            mem_a      = addr0;
            mem_din    = wdata0;
            mem_mwrite = we0;
            mem_mread  = ~we0;
        end else if (gnt1) begin
            mem_a      = addr1;
            mem_din    = wdata1;
            mem_mwrite = we1;
            mem_mread  = ~we1;
        end
    end

    // lastGnt = 1 means port 1 was served last, so port 0 wins the next tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lastGnt <= 1'b1;
        end else begin
            state <= nextState;
            if (gnt0) begin
                lastGnt <= 1'b0;
            end else if (gnt1) begin
                lastGnt <= 1'b1;
            end
        end
    end

    mem_arb_rport #(.DW(S)) u_rport0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (gnt0 & ~we0),
        .din     (mem_dout),
        .rdata   (rdata0),
        .rvalid  (rvalid0)
    );

    mem_arb_rport #(.DW(S)) u_rport1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (gnt1 & ~we1),
        .din     (mem_dout),
        .rdata   (rdata1),
        .rvalid  (rvalid1)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural memory attached to
// the mem_* port; memory is preloaded with 0xA5000000 | address.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  mem_a;
    logic [31:0] mem_din, mem_dout;
    logic        mem_mread, mem_mwrite;

    logic [31:0] mem [256];
    logic        preload = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: combinational read, write commits at the rising edge
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_mwrite) begin
            mem[mem_a] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_a];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_mread(mem_mread), .mem_mwrite(mem_mwrite)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic k0,
                                 input logic [7:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic k1,
                                 input logic [7:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; lock0 = k0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = k1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkGrants(input string tag, input logic e0, input logic e1);
        #2;
        checkOutput({tag, "_gnt0"}, 32'(gnt0), 32'(e0));
        checkOutput({tag, "_gnt1"}, 32'(gnt1), 32'(e1));
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1, 0, 0, 8'h01, 0, 1, 0, 0, 8'h02, 0);
        #2;
        checkGrants("rst", 0, 0);
        checkOutput("rst_mread", 32'(mem_mread), 0);
        checkOutput("rst_mwrite", 32'(mem_mwrite), 0);
        tick();
        preload = 1'b0;
        tick();
        checkOutput("rst_rvalid0", 32'(rvalid0), 0);
        checkOutput("rst_rdata0", rdata0, 0);

        // Both ports request continuously: port 0 first, then alternate
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkGrants($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            checkOutput($sformatf("rr%0d_a", i), 32'(mem_a), (i % 2) == 0 ? 32'h01 : 32'h02);
            tick();
        end
        checkOutput("rr_rvalid1", 32'(rvalid1), 1);
        checkOutput("rr_rdata1", rdata1, 32'hA500_0002);
        checkOutput("rr_rdata0", rdata0, 32'hA500_0001);

        // Port 0 writes, port 1 reads it back the next cycle
        applyStimulus(1, 1, 0, 8'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        checkGrants("wr", 1, 0);
        checkOutput("wr_mwrite", 32'(mem_mwrite), 1);
        checkOutput("wr_din", mem_din, 32'hDEAD_BEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
        checkGrants("rd", 0, 1);
        checkOutput("rd_mread", 32'(mem_mread), 1);
        tick();
        checkOutput("rd_rvalid1", 32'(rvalid1), 1);
        checkOutput("rd_rdata1", rdata1, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 8'h33, 32'h1111_1111, 0, 0, 0, 8'h44, 0);
        checkGrants("idle", 0, 0);
        checkOutput("idle_a", 32'(mem_a), 0);
        checkOutput("idle_din", mem_din, 0);
        checkOutput("idle_mread", 32'(mem_mread), 0);
        tick();
        checkOutput("idle_rvalid1", 32'(rvalid1), 0);
        checkOutput("idle_rdata1", rdata1, 32'hDEAD_BEEF);

        // Back-to-back reads on port 0
        applyStimulus(1, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0);
        checkGrants("b2b0", 1, 0);
        tick();
        checkOutput("b2b0_rvalid", 32'(rvalid0), 1);
        checkOutput("b2b0_rdata", rdata0, 32'hA500_00FF);
        applyStimulus(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        checkGrants("b2b1", 1, 0);
        tick();
        checkOutput("b2b1_rvalid", 32'(rvalid0), 1);
        checkOutput("b2b1_rdata", rdata0, 32'hA500_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("b2b_rvalid_off", 32'(rvalid0), 0);
        checkOutput("b2b_hold", rdata0, 32'hA500_0000);

        // Port 1 locks over four reads while port 0 keeps requesting
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 8'h05, 0, 1, 0, i < 3, 8'(i), 0);
            checkGrants($sformatf("lock%0d", i), 0, 1);
            tick();
        end
        applyStimulus(1, 0, 1, 8'h05, 0, 0, 0, 0, 0, 0);
        checkOutput("lock_rvalid1", 32'(rvalid1), 1);
        checkOutput("lock_rdata1", rdata1, 32'hA500_0003);
        checkGrants("unlock", 1, 0);
        tick();
        checkOutput("own0_rdata0", rdata0, 32'hA500_0005);

        // Port 0 owns but goes quiet; port 1 must stay blocked
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 8'h30, 32'h1234_5678);
            checkGrants($sformatf("quiet%0d", i), 0, 0);
            checkOutput($sformatf("quiet%0d_mwrite", i), 32'(mem_mwrite), 0);
            checkOutput($sformatf("quiet%0d_mread", i), 32'(mem_mread), 0);
            tick();
        end
        checkOutput("quiet_mem30", mem[8'h30], 32'hA500_0030);
        applyStimulus(1, 1, 0, 8'h40, 32'hCAFE_F00D, 1, 1, 1, 8'h30, 32'h1234_5678);
        checkGrants("release0", 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 8'h30, 32'h1234_5678);
        checkGrants("take1", 0, 1);
        tick();
        checkOutput("mem40", mem[8'h40], 32'hCAFE_F00D);
        checkOutput("mem30", mem[8'h30], 32'h1234_5678);

        // Reset while port 1 owns with a write pending
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 8'h20, 32'hBAD0_BAD0);
        rst_n = 1'b0;
        checkGrants("rstown", 0, 0);
        checkOutput("rstown_mwrite", 32'(mem_mwrite), 0);
        tick();
        checkOutput("rstown_mem20", mem[8'h20], 32'hA500_0020);
        checkOutput("rstown_rdata1", rdata1, 0);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 8'h40, 0, 1, 0, 0, 8'h30, 0);
        checkGrants("post_rst_tie", 1, 0);
        tick();
        checkOutput("post_rst_rdata0", rdata0, 32'hCAFE_F00D);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 8'h30, 0);
        checkGrants("post_rst_p1", 0, 1);
        tick();
        checkOutput("post_rst_rvalid1", 32'(rvalid1), 1);
        checkOutput("post_rst_rdata1", rdata1, 32'h1234_5678);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
